// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: SPI mode-0 slave returning the 5-byte joystick packet
// and decoding the first MOSI byte as the LED command.
//
// state | meaning
// IDLE  | waiting for an accepted SS fall, miso held low
// SHIFT | frame active, shifting tx out and rx in until 40 bits
// HOLD  | 40 bits done, extra SCLK edges ignored, waiting for SS rise
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] joy_x,
  input  logic [9:0] joy_y,
  input  logic [2:0] btn,
  output logic [1:0] led,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [1:0]             state;
  logic [39:0]            tx;
  logic [39:0]            packet;
  logic [7:0]             rx;
  logic [7:0]             rx_next;
  logic [5:0]             bitcnt;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // ss_d clears on reset, so a fall needs SS to be seen high first.
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign packet  = {joy_x[7:0], 6'b0, joy_x[9:8], joy_y[7:0], 6'b0, joy_y[9:8], 5'b0, btn};
  assign rx_next = {rx[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (clr) begin
      ss_sync    <= '0;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      ss_d       <= 1'b0;
      sclk_d     <= 1'b0;
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bitcnt     <= '0;
      miso       <= 1'b0;
      led        <= 2'b00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d       <= ss_s;
      sclk_d     <= sclk_s;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          busy <= 1'b0;
          if (ss_fall) begin
            tx     <= packet;
            miso   <= packet[39];
            bitcnt <= '0;
            rx     <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // 40 bits in but SS rose before the final fall still counts as done
            if (bitcnt == 6'd40) frame_done <= 1'b1;
            else                 frame_err  <= 1'b1;
            miso  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sclk_rise) begin
            rx     <= rx_next;
            bitcnt <= bitcnt + 6'd1;
            if (bitcnt == 6'd7 && rx_next[7:2] == 6'b100000) led <= rx_next[1:0];
          end else if (sclk_fall) begin
            if (bitcnt == 6'd40) begin
              miso  <= 1'b0;
              state <= HOLD;
            end else begin
              tx   <= {tx[38:0], 1'b0};
              miso <= tx[38];
            end
          end
        end
        HOLD: begin
          miso <= 1'b0;
          if (ss_rise) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          miso  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed and randomized SPI frames against a packet/LED reference model.
module tb_jstk_spi_responder;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [9:0] joy_x = '0;
  logic [9:0] joy_y = '0;
  logic [2:0] btn = '0;
  logic       miso;
  logic [1:0] led;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  int n_err = 0;
  logic [1:0] led_m = 2'b00;

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .clr(clr), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .joy_x(joy_x), .joy_y(joy_y), .btn(btn), .led(led), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One SS-framed transfer of nbits mode-0 clocks; joy_x may be changed after bit chg_bit.
  task automatic run_frame(input int nbits, input logic [7:0] cmd, input int chg_bit,
                           input logic [9:0] chg_x, input string tag);
    logic [39:0] exp;
    logic [47:0] got;
    logic [47:0] exp48;
    int d0, e0;
    logic ed;
    exp = {joy_x[7:0], 6'b0, joy_x[9:8], joy_y[7:0], 6'b0, joy_y[9:8], 5'b0, btn};
    got = '0;
    d0 = n_done;
    e0 = n_err;
    ed = (nbits >= 40);
    ss = 1'b0;
    tick(2);
    check({tag, " busy_pre"}, 48'(busy), 48'd0);
    tick(1);
    check({tag, " busy_rise"}, 48'(busy), 48'd1);
    check({tag, " miso_first"}, 48'(miso), 48'(exp[39]));
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) mosi = cmd[7-i];
      else       mosi = 1'($urandom);
      tick(HALF);
      got = {got[46:0], miso};
      sclk = 1'b1;
      if (i + 1 == chg_bit) joy_x = chg_x;
      tick(HALF);
      sclk = 1'b0;
    end
    if (nbits >= 8 && cmd[7:2] == 6'b100000) led_m = cmd[1:0];
    tick(HALF);
    ss = 1'b1;
    tick(2);
    check({tag, " busy_hold"}, 48'(busy), 48'd1);
    tick(1);
    check({tag, " busy_fall"}, 48'(busy), 48'd0);
    check({tag, " done_pulse"}, 48'(frame_done), 48'(ed));
    check({tag, " err_pulse"}, 48'(frame_err), 48'(!ed));
    tick(6);
    exp48 = {exp, 8'b0} >> (48 - nbits);
    check({tag, " packet"}, got, exp48);
    check({tag, " led"}, 48'(led), 48'(led_m));
    check({tag, " done_cnt"}, 48'(n_done - d0), 48'(ed));
    check({tag, " err_cnt"}, 48'(n_err - e0), 48'(!ed));
  endtask

  initial begin
    int d0, e0;
    logic [7:0] cmd;

    tick(3);
    check("rst miso", 48'(miso), 48'd0);
    check("rst led", 48'(led), 48'd0);
    check("rst busy", 48'(busy), 48'd0);
    check("rst done", 48'(frame_done), 48'd0);
    check("rst err", 48'(frame_err), 48'd0);
    clr = 1'b0;
    tick(6);

    joy_x = 10'h2A5; joy_y = 10'h13C; btn = 3'b101;
    run_frame(40, 8'h83, -1, '0, "full");
    run_frame(40, 8'h43, -1, '0, "badcmd");
    run_frame(17, 8'h81, -1, '0, "abort");
    joy_x = 10'h155; joy_y = 10'h2AA; btn = 3'b010;
    run_frame(40, 8'h81, -1, '0, "post_abort");

    for (int k = 0; k < 5; k++) begin
      joy_x = 10'($urandom);
      joy_y = 10'($urandom);
      btn   = 3'($urandom);
      if ($urandom_range(0, 1) == 1) cmd = {6'b100000, 2'($urandom)};
      else                           cmd = 8'($urandom);
      run_frame(40, cmd, -1, '0, "random");
    end

    run_frame(48, 8'h82, -1, '0, "overrun");

    joy_x = 10'h000;
    run_frame(40, 8'h83, 4, 10'h3FF, "snap_cur");
    run_frame(40, 8'h82, -1, '0, "snap_next");

    // clr at bit 20 with SS held low
    d0 = n_done;
    e0 = n_err;
    ss = 1'b0;
    tick(8);
    for (int i = 0; i < 20; i++) begin
      mosi = (i < 8) ? ((8'h81 >> (7 - i)) & 8'h01) != 0 : 1'b1;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      if (i < 19) sclk = 1'b0;
    end
    check("rst_mid led_before", 48'(led), 48'd1);
    check("rst_mid busy_before", 48'(busy), 48'd1);
    clr = 1'b1;
    tick(1);
    led_m = 2'b00;
    check("rst_mid miso", 48'(miso), 48'd0);
    check("rst_mid led", 48'(led), 48'd0);
    check("rst_mid busy", 48'(busy), 48'd0);
    check("rst_mid err", 48'(frame_err), 48'd0);
    clr = 1'b0;
    sclk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    check("rst_mid busy_ignored", 48'(busy), 48'd0);
    check("rst_mid miso_ignored", 48'(miso), 48'd0);
    check("rst_mid led_ignored", 48'(led), 48'd0);
    ss = 1'b1;
    tick(8);
    check("rst_mid err_cnt", 48'(n_err - e0), 48'd0);
    check("rst_mid done_cnt", 48'(n_done - d0), 48'd0);
    joy_x = 10'h0F0; joy_y = 10'h30F; btn = 3'b111;
    run_frame(40, 8'h83, -1, '0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
